// File: rtl/edit_mode_controller.sv
// Multi-field edit-session controller: one button enters/steps/commits, one aborts, with an
// inactivity timeout and warning window. Define EDIT_BLINK_EN to enable the blink phase toggle.
module edit_mode_controller #(
   parameter int unsigned NUM_FIELDS      = 4,
   parameter int unsigned TIMEOUT_SECONDS = 15,
   parameter int unsigned WARN_SECONDS    = 3,
   parameter int unsigned FW              = 2,
   parameter int unsigned CW              = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          btn_mode_pulse,
   input  logic          btn_cancel_pulse,
   input  logic          activity_pulse,
   input  logic          tick_1s,
   output logic          edit_active,
   output logic [FW-1:0] field_sel,
   output logic [CW-1:0] secs_left,
   output logic          timeout_warn,
   output logic          commit_pulse,
   output logic          cancel_pulse,
   output logic          mode_timeout,
   output logic          blink
);

   localparam logic [FW-1:0] LastField = FW'(NUM_FIELDS - 1);
   localparam logic [CW-1:0] SecsLoad  = CW'(TIMEOUT_SECONDS);
   localparam logic [CW-1:0] SecsWarn  = CW'(WARN_SECONDS);
   localparam logic [CW-1:0] SecsOne   = CW'(1);

   typedef enum logic [0:0] {StIdle, StEdit} state_e;

   state_e        state_q, state_d;
   logic [FW-1:0] field_q, field_d;
   logic [CW-1:0] secs_q, secs_d;
   logic          commit_q, commit_d;
   logic          cancel_q, cancel_d;
   logic          timeout_q, timeout_d;
   logic          reload;
   logic          tick_dec;

   always_comb begin
      state_d   = state_q;
      field_d   = field_q;
      secs_d    = secs_q;
      commit_d  = 1'b0;
      cancel_d  = 1'b0;
      timeout_d = 1'b0;
      reload    = 1'b0;
      tick_dec  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (btn_mode_pulse) begin
               state_d = StEdit;
               field_d = '0;
               secs_d  = SecsLoad;
               reload  = 1'b1;
            end
         end
         StEdit: begin
            // Strict priority: one event acts per cycle, lower ones are dropped.
            if (btn_cancel_pulse) begin
               state_d  = StIdle;
               cancel_d = 1'b1;
            end else if (btn_mode_pulse) begin
               if (field_q < LastField) begin
                  field_d = field_q + FW'(1);
                  secs_d  = SecsLoad;
                  reload  = 1'b1;
               end else begin
                  state_d  = StIdle;
                  commit_d = 1'b1;
               end
            end else if (activity_pulse) begin
               secs_d = SecsLoad;
               reload = 1'b1;
            end else if (tick_1s) begin
               if (secs_q > SecsOne) begin
                  secs_d   = secs_q - SecsOne;
                  tick_dec = 1'b1;
               end else begin
                  state_d   = StIdle;
                  timeout_d = 1'b1;
               end
            end
            if (state_d == StIdle) begin
               field_d = '0;
               secs_d  = '0;
            end
         end
         default: begin
            state_d = StIdle;
            field_d = '0;
            secs_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         field_q   <= '0;
         secs_q    <= '0;
         commit_q  <= 1'b0;
         cancel_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         field_q   <= field_d;
         secs_q    <= secs_d;
         commit_q  <= commit_d;
         cancel_q  <= cancel_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef EDIT_BLINK_EN
   logic blink_q, blink_d;

   // Held high whenever a field becomes freshly visible; only surviving ticks toggle it.
   always_comb begin
      blink_d = blink_q;
      if (state_d == StIdle || reload) begin
         blink_d = 1'b1;
      end else if (tick_dec) begin
         blink_d = ~blink_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_q <= 1'b1;
      end else begin
         blink_q <= blink_d;
      end
   end

   assign blink = blink_q;
`else
   logic unused_blink;
   assign unused_blink = reload ^ tick_dec;
   assign blink        = 1'b1;
`endif

   assign edit_active  = (state_q == StEdit);
   assign field_sel    = field_q;
   assign secs_left    = secs_q;
   assign timeout_warn = edit_active && (secs_q <= SecsWarn);
   assign commit_pulse = commit_q;
   assign cancel_pulse = cancel_q;
   assign mode_timeout = timeout_q;

endmodule

// File: tb/tb_edit_mode_controller.sv
// Self-checking bench for edit_mode_controller: directed scenarios plus randomized pulses
// compared each cycle against a session-level reference model.
module tb_edit_mode_controller;

   localparam int NF = 4;
   localparam int TO = 15;
   localparam int WS = 3;
   localparam int FW = 2;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          btn_mode_pulse, btn_cancel_pulse, activity_pulse, tick_1s;
   logic          edit_active, timeout_warn, commit_pulse, cancel_pulse, mode_timeout, blink;
   logic [FW-1:0] field_sel;
   logic [CW-1:0] secs_left;

   edit_mode_controller #(
      .NUM_FIELDS     (NF),
      .TIMEOUT_SECONDS(TO),
      .WARN_SECONDS   (WS),
      .FW             (FW),
      .CW             (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .btn_mode_pulse  (btn_mode_pulse),
      .btn_cancel_pulse(btn_cancel_pulse),
      .activity_pulse  (activity_pulse),
      .tick_1s         (tick_1s),
      .edit_active     (edit_active),
      .field_sel       (field_sel),
      .secs_left       (secs_left),
      .timeout_warn    (timeout_warn),
      .commit_pulse    (commit_pulse),
      .cancel_pulse    (cancel_pulse),
      .mode_timeout    (mode_timeout),
      .blink           (blink)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: session state as plain integers.
   bit m_active;
   int m_field, m_secs;
   bit m_commit, m_cancel, m_tmo, m_blink;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_field = 0; m_secs = 0;
      m_commit = 0; m_cancel = 0; m_tmo = 0; m_blink = 1;
   endtask

   task automatic model_exit();
      m_active = 0; m_field = 0; m_secs = 0; m_blink = 1;
   endtask

   task automatic model_step(input bit m, input bit c, input bit a, input bit t);
      m_commit = 0; m_cancel = 0; m_tmo = 0;
      if (!m_active) begin
         if (m) begin
            m_active = 1; m_field = 0; m_secs = TO; m_blink = 1;
         end
      end else if (c) begin
         model_exit(); m_cancel = 1;
      end else if (m) begin
         if (m_field + 1 < NF) begin
            m_field++; m_secs = TO; m_blink = 1;
         end else begin
            model_exit(); m_commit = 1;
         end
      end else if (a) begin
         m_secs = TO; m_blink = 1;
      end else if (t) begin
         if (m_secs > 1) begin
            m_secs--;
`ifdef EDIT_BLINK_EN
            m_blink = !m_blink;
`endif
         end else begin
            model_exit(); m_tmo = 1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".active"}, 32'(edit_active), 32'(m_active));
      check({tag, ".field"}, 32'(field_sel), 32'(m_field));
      check({tag, ".secs"}, 32'(secs_left), 32'(m_secs));
      check({tag, ".warn"}, 32'(timeout_warn), 32'(m_active && m_secs <= WS));
      check({tag, ".commit"}, 32'(commit_pulse), 32'(m_commit));
      check({tag, ".cancel"}, 32'(cancel_pulse), 32'(m_cancel));
      check({tag, ".timeout"}, 32'(mode_timeout), 32'(m_tmo));
      check({tag, ".blink"}, 32'(blink), 32'(m_blink));
   endtask

   // Drive one cycle of pulses, then compare just after the edge.
   task automatic step(input string tag, input bit m, input bit c, input bit a, input bit t);
      btn_mode_pulse = m; btn_cancel_pulse = c; activity_pulse = a; tick_1s = t;
      @(posedge clk);
      #1;
      model_step(m, c, a, t);
      btn_mode_pulse = 0; btn_cancel_pulse = 0; activity_pulse = 0; tick_1s = 0;
      check_all(tag);
   endtask

   initial begin
      reset = 1;
      btn_mode_pulse = 0; btn_cancel_pulse = 0; activity_pulse = 0; tick_1s = 0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      reset = 0;
      @(posedge clk);
      #1;

      // Entry
      step("enter", 1, 0, 0, 0);
      check("enter_secs", 32'(secs_left), 32'd15);
      // Step through fields to commit
      for (int i = 0; i < NF; i++) step("advance", 1, 0, 0, 0);
      check("commit_seen", 32'(commit_pulse), 32'd1);
      step("commit_one_cycle", 0, 0, 0, 0);

      // Inactivity timeout
      step("enter_t", 1, 0, 0, 0);
      for (int i = 0; i < TO; i++) step("tick", 0, 0, 0, 1);
      check("timeout_seen", 32'(mode_timeout), 32'd1);
      step("after_timeout", 0, 0, 0, 1);

      // Activity reload and masked tick
      step("enter_a", 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step("tick_a", 0, 0, 0, 1);
      check("secs_five", 32'(secs_left), 32'd5);
      step("activity", 0, 0, 1, 0);
      step("activity_tick", 0, 0, 1, 1);
      check("tick_dropped", 32'(secs_left), 32'd15);

      // Cancel beats mode on the last field
      for (int i = 0; i < 3; i++) step("to_f3", 1, 0, 0, 0);
      step("cancel_mode", 1, 1, 0, 0);
      check("cancel_not_commit", 32'(commit_pulse), 32'd0);
      step("idle_cancel", 0, 1, 0, 0);
      step("idle_act", 0, 0, 1, 0);
      step("idle_tick", 0, 0, 0, 1);

      // Blink phase and async reset mid-session
      step("enter_b", 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("blink_tick", 0, 0, 0, 1);
      step("blink_adv", 1, 0, 0, 0);
      step("to_f2", 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) step("tick_r", 0, 0, 0, 1);
      check("pre_reset_secs", 32'(secs_left), 32'd7);
      @(negedge clk);
      reset = 1;
      #1;
      model_reset();
      check_all("async_reset");
      @(negedge clk);
      reset = 0;
      @(posedge clk);
      #1;
      check_all("post_reset");

      // Randomized phases: busy user vs. quiet (mostly ticks)
      for (int ph = 0; ph < 16; ph++) begin
         bit quiet;
         quiet = ph[0];
         for (int i = 0; i < 150; i++) begin
            bit m, c, a, t;
            m = quiet ? ($urandom_range(99) < 2) : ($urandom_range(99) < 12);
            c = ($urandom_range(99) < (quiet ? 1 : 3));
            a = quiet ? 1'b0 : ($urandom_range(99) < 8);
            t = ($urandom_range(99) < (quiet ? 60 : 30));
            step("rand", m, c, a, t);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
